// File: rtl/tcore_param.sv
// Core-wide shared types: memory access sizes and the exception encoding carried
// down the pipeline.
package tcore_param;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_e;

  typedef enum logic [3:0] {
    NO_EXCEPTION       = 4'd0,
    INSTR_MISALIGNED   = 4'd1,
    INSTR_ACCESS_FAULT = 4'd2,
    ILLEGAL_INSTR      = 4'd3,
    LOAD_MISALIGNED    = 4'd4,
    LOAD_ACCESS_FAULT  = 4'd5,
    STORE_MISALIGNED   = 4'd6,
    STORE_ACCESS_FAULT = 4'd7
  } exc_type_e;

endpackage

// File: rtl/stage4_memory_lane_align.sv
// Byte-lane steering for a 32-bit data port: store byte enables and lane-replicated
// write data, plus load byte/halfword extraction with sign or zero extension.
module mem_lane_align
  import tcore_param::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  mem_size_e             size,
  input  logic      [1:0]       offset,
  input  logic                  ld_unsigned,
  input  logic      [XLEN-1:0]  store_data,
  input  logic      [XLEN-1:0]  read_word,
  output logic      [3:0]       be,
  output logic      [XLEN-1:0]  lane_wdata,
  output logic      [XLEN-1:0]  load_data
);

  logic [XLEN-1:0] shifted;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;

  assign shifted  = read_word >> {offset, 3'b000};
  assign byte_sel = shifted[7:0];
  assign half_sel = offset[1] ? read_word[31:16] : read_word[15:0];

  // Size encoding 2'b11 falls into the word arm.
  always_comb begin
    be         = 4'b1111;
    lane_wdata = store_data;
    load_data  = read_word;
    case (size)
      MEM_BYTE: begin
        be         = 4'b0001 << offset;
        lane_wdata = {4{store_data[7:0]}};
        load_data  = {{(XLEN-8){~ld_unsigned & byte_sel[7]}}, byte_sel};
      end
      MEM_HALF: begin
        be         = offset[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{store_data[15:0]}};
        load_data  = {{(XLEN-16){~ld_unsigned & half_sel[15]}}, half_sel};
      end
      default: begin
        be         = 4'b1111;
        lane_wdata = store_data;
        load_data  = read_word;
      end
    endcase
  end

endmodule

// File: rtl/stage4_memory.sv
// Memory-access pipeline stage: runs one aligned load/store per instruction on a
// request/grant/response port, stalls until it completes, and merges exceptions.
module stage4_memory
  import tcore_param::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic             rd_mem_i,
  input  logic             wr_mem_i,
  input  mem_size_e        mem_size_i,
  input  logic             ld_unsigned_i,
  input  logic [XLEN-1:0]  alu_result_i,
  input  logic [XLEN-1:0]  write_data_i,
  input  exc_type_e        exc_type_i,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  output logic [XLEN-1:0]  dmem_addr_o,
  output logic [3:0]       dmem_be_o,
  output logic [XLEN-1:0]  dmem_wdata_o,
  input  logic             dmem_gnt_i,
  input  logic             dmem_rvalid_i,
  input  logic             dmem_err_i,
  input  logic [XLEN-1:0]  dmem_rdata_i,
  output logic [XLEN-1:0]  rd_data_o,
  output logic             mem_stall_o,
  output exc_type_e        exc_type_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_e;

  lsu_state_e      state_q;
  logic            req_q, we_q, err_q;
  logic [XLEN-1:0] addr_q, wdata_q, load_q;
  logic [3:0]      be_q;

  logic            mem_op, misaligned, no_exc, acc;
  logic [3:0]      be;
  logic [XLEN-1:0] lane_wdata, load_data;

  mem_lane_align #(.XLEN(XLEN)) u_align (
    .size        (mem_size_i),
    .offset      (alu_result_i[1:0]),
    .ld_unsigned (ld_unsigned_i),
    .store_data  (write_data_i),
    .read_word   (dmem_rdata_i),
    .be          (be),
    .lane_wdata  (lane_wdata),
    .load_data   (load_data)
  );

  assign mem_op = valid_i & (rd_mem_i | wr_mem_i);
  assign no_exc = (exc_type_i == NO_EXCEPTION);

  always_comb begin
    misaligned = 1'b0;
    case (mem_size_i)
      MEM_BYTE: misaligned = 1'b0;
      MEM_HALF: misaligned = alu_result_i[0];
      default:  misaligned = |alu_result_i[1:0];
    endcase
    misaligned = misaligned & mem_op;
  end

  assign acc = mem_op & no_exc & ~misaligned;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      load_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (acc) begin
          req_q   <= 1'b1;
          we_q    <= wr_mem_i;
          addr_q  <= {alu_result_i[XLEN-1:2], 2'b00};
          be_q    <= be;
          wdata_q <= lane_wdata;
          state_q <= REQ;
        end
        REQ: if (dmem_gnt_i) begin
          req_q   <= 1'b0;
          state_q <= WAIT;
        end
        WAIT: if (dmem_rvalid_i) begin
          load_q  <= load_data;
          err_q   <= dmem_err_i;
          state_q <= DONE;
        end
        DONE: state_q <= IDLE;
      endcase
    end
  end

  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;

  assign mem_stall_o = ~rst_i & (((state_q == IDLE) & acc) | (state_q == REQ) |
                                 (state_q == WAIT));
  assign rd_data_o   = ((state_q == DONE) & ~we_q) ? load_q : alu_result_i;

  // Upstream exceptions win, then misalignment, then a bus fault reported in DONE.
  always_comb begin
    exc_type_o = NO_EXCEPTION;
    if (!no_exc) begin
      exc_type_o = exc_type_i;
    end else if (misaligned) begin
      exc_type_o = wr_mem_i ? STORE_MISALIGNED : LOAD_MISALIGNED;
    end else if ((state_q == DONE) && err_q) begin
      exc_type_o = we_q ? STORE_ACCESS_FAULT : LOAD_ACCESS_FAULT;
    end
  end

endmodule

// File: doc/stage4_memory.md
# stage4_memory

Memory-access pipeline stage between execution and writeback. Takes the execution-stage ALU result as the effective address and the forwarded rs2 value as store data. It runs byte-lane aligned load/store transactions on a request/grant/response data-memory port, stalling the pipeline until each access completes. It produces the writeback value (sign- or zero-extended load data, or the ALU result passed through) and merges misalignment and access-fault exceptions into the incoming exception type.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; one clock, synchronous, active-high.
- valid_i  in  1  instruction present in this stage.
- rd_mem_i  in  1  instruction is a load.
- wr_mem_i  in  1  instruction is a store.
- mem_size_i  in  mem_size_e  access size: MEM_BYTE, MEM_HALF or MEM_WORD.
- ld_unsigned_i  in  1  zero-extend load data (LBU/LHU).
- alu_result_i  in  XLEN  effective address, or the result of a non-memory instruction.
- write_data_i  in  XLEN  store data, right-aligned.
- exc_type_i  in  exc_type_e  exception from earlier stages.
- dmem_req_o  out  1  request valid.
- dmem_we_o  out  1  request is a write.
- dmem_addr_o  out  XLEN  word-aligned address; [1:0] = 0.
- dmem_be_o  out  4  byte enables.
- dmem_wdata_o  out  XLEN  lane-replicated store data.
- dmem_gnt_i  in  1  request accepted.
- dmem_rvalid_i  in  1  response valid; applies to both reads and writes.
- dmem_err_i  in  1  bus error; qualified by dmem_rvalid_i.
- dmem_rdata_i  in  XLEN  read word.
- rd_data_o  out  XLEN  writeback value.
- mem_stall_o  out  1  hold the upstream pipeline.
- exc_type_o  out  exc_type_e  merged exception.

## Operation
- Access: `acc = valid_i & (rd_mem_i | wr_mem_i) & exc_type_i==NO_EXCEPTION & ~misaligned`. If rd_mem_i and wr_mem_i are both set, the access is a store.
- Misalignment:
  - MEM_HALF with addr[0]=1.
  - MEM_WORD with addr[1:0]≠0.
  - Encoding 2'b11 is treated as MEM_WORD.
- Misaligned accesses:
  - issue no bus request and cause no stall;
  - exc_type_o = LOAD_MISALIGNED or STORE_MISALIGNED, combinationally.
- Exception priority: exc_type_i ≠ NO_EXCEPTION overrides everything and suppresses the access.
- Store lanes:
  - byte: be = 4'b0001 << addr[1:0]; wdata = {4{data[7:0]}}.
  - half: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{data[15:0]}}.
  - word: be = 4'b1111; wdata = data.
- Loads: dmem_be_o is driven exactly as for a store of the same size.
- Load extract:
  - Select the byte or halfword at addr[1:0] from dmem_rdata_i.
  - Sign-extend, or zero-extend when ld_unsigned_i=1.
  - Register the result in load_q when the response arrives.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: if acc, latch addr/be/wdata/we into the request registers → REQ. mem_stall_o=1 combinationally.
  - REQ: dmem_req_o=1 with stable registered fields; mem_stall_o=1; on dmem_gnt_i → WAIT.
  - WAIT: mem_stall_o=1; on dmem_rvalid_i, capture load_q and err_q → DONE. dmem_rvalid_i outside WAIT is ignored.
  - DONE: mem_stall_o=0 and the pipeline advances; rd_data_o = load_q for loads. If err_q, exc_type_o = LOAD_ACCESS_FAULT or STORE_ACCESS_FAULT. Always → IDLE.
- rd_data_o = alu_result_i, combinationally, in every case except a load in DONE.

## Timing
- Reset values (any state → IDLE on rst_i, including mid-transaction):
  - dmem_req_o = 0, dmem_we_o = 0, dmem_addr_o = 0, dmem_be_o = 0, dmem_wdata_o = 0.
  - load_q = 0, err_q = 0.
  - mem_stall_o = 0 in the reset cycle.
  - An outstanding bus response after reset is dropped, because IDLE ignores dmem_rvalid_i.
- Best-case access: IDLE(acc) → REQ(gnt) → WAIT(rvalid) → DONE. That is 3 stall cycles; the instruction leaves at the end of the DONE cycle.
- The grant may take arbitrarily long. dmem_req_o and all request fields must hold constant until the cycle in which dmem_gnt_i=1.
- dmem_rvalid_i is accepted no earlier than the cycle after the grant.
- dmem_req_o is never asserted in IDLE, WAIT or DONE.
- Back-to-back accesses: the instruction after a DONE is evaluated in IDLE on the next cycle, so there is one bubble-free restart.
- Non-memory and excepting instructions take 0 extra cycles.

## Structure
- Shared package tcore_param, add:
  - mem_size_e (MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b10).
  - exc_type_e members LOAD_MISALIGNED, STORE_MISALIGNED, LOAD_ACCESS_FAULT, STORE_ACCESS_FAULT.
- Local to the module: lsu_state_e (IDLE, REQ, WAIT, DONE).
- Sub-module: mem_lane_align, a combinational unit that generates be/wdata and performs the load extract/extension. It is reused by the future cache path.

## Test plan
- LB, addr 0x1003, rdata 0x80FF_1234, gnt and rvalid immediate → stall asserted for 3 cycles; rd_data_o = 0xFFFF_FF80 in DONE. Repeat as LBU → 0x0000_0080.
- SH, addr 0x2002, data 0x0000_ABCD, gnt delayed 4 cycles → req/addr 0x2000/be 4'b1100/wdata 0xABCD_ABCD held stable until gnt; stall lasts 7 cycles.
- LW, addr 0x3001 → no dmem_req_o; mem_stall_o=0; exc_type_o = LOAD_MISALIGNED in the same cycle.
- SW with exc_type_i = INSTR_MISALIGNED → no request; exc_type_o = INSTR_MISALIGNED.
- LW, addr 0x4000, with rvalid and err=1 → exc_type_o = LOAD_ACCESS_FAULT in DONE only; the next instruction sees NO_EXCEPTION.
- rst_i asserted in WAIT → next cycle IDLE with all outputs 0; a late rvalid produces no effect.
